// File: rtl/wdg_stage_ctrl_if.sv
// wdg_stage_ctrl_if: signal bundle between the watchdog tick counter side
// and the staged escalation controller.
// Optional feature macro: WDG_WINDOW_EN (adds win_thrhd).
//
// Transfer semantics: there is no valid/ready pair on this bundle. mtick and
// kick are single-cycle strobes that are consumed unconditionally on the
// rising edge where they are high (the controller is always ready); all other
// inputs are levels sampled every edge. Outputs are registered levels, except
// cnt_clr_n, which also carries a one-cycle low pulse after an accepted kick.
interface wdg_stage_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             mtick;
  logic [WIDTH-1:0] count_wdg;
  logic [WIDTH-1:0] cnt_thrhd;
  logic             wdg_en;
  logic             kick;
`ifdef WDG_WINDOW_EN
  logic [WIDTH-1:0] win_thrhd;
`endif
  logic             cnt_clr_n;
  logic             wdg_irq;
  logic             wdg_rst_req;
  logic [1:0]       stage;

  // Upstream side: counter, software service and enable sources.
  modport master (
`ifdef WDG_WINDOW_EN
    output win_thrhd,
`endif
    output mtick, count_wdg, cnt_thrhd, wdg_en, kick,
    input  cnt_clr_n, wdg_irq, wdg_rst_req, stage
  );

  // Controller side.
  modport slave (
`ifdef WDG_WINDOW_EN
    input  win_thrhd,
`endif
    input  mtick, count_wdg, cnt_thrhd, wdg_en, kick,
    output cnt_clr_n, wdg_irq, wdg_rst_req, stage
  );
endinterface

// File: rtl/wdg_stage_ctrl.sv
// wdg_stage_ctrl: staged watchdog escalation controller.
// Each counter wrap escalates ARMED -> STAGE1 (bark, wdg_irq) and, after
// S1_WRAPS further wraps, STAGE2 (bite, wdg_rst_req for RST_LEN cycles).
// A kick services the watchdog and pulses the counter clear low for one cycle.
// Optional feature macro: WDG_WINDOW_EN (early-kick window via win_thrhd).
// The FSM state is visible on the stage output (0..3).
module wdg_stage_ctrl #(
  parameter int WIDTH    = 4,
  parameter int S1_WRAPS = 1,
  parameter int RST_LEN  = 4
) (
  input  logic              sys_clk,
  input  logic              res,
  wdg_stage_ctrl_if.slave   bus
);

  localparam int WC_W = $clog2(S1_WRAPS + 1);
  localparam int PC_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(S1_WRAPS - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(RST_LEN - 1);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_STAGE1   = 2'd2,
    ST_STAGE2   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_wrap_cnt;
  logic [PC_W-1:0]  r_pulse_cnt;
  logic             r_irq;
  logic             r_rst_req;
  logic             r_clr_n;

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_thrhd;
  logic             w_wrap;
  logic             w_early_kick;

  assign w_count = bus.count_wdg;
  assign w_thrhd = bus.cnt_thrhd;
  assign w_wrap  = bus.mtick & (w_count == w_thrhd);

`ifdef WDG_WINDOW_EN
  // A kick arriving before the counter reaches the window is treated as a
  // runaway service loop; a zero window turns the check off.
  assign w_early_kick = (bus.win_thrhd != '0) && (w_count < bus.win_thrhd);
`else
  assign w_early_kick = 1'b0;
`endif

  // Escalation FSM with all outputs registered; priority inside a state is
  // bite lock > disable > kick > wrap.
  always_ff @(posedge sys_clk) begin
    if (res) begin
      r_state     <= ST_DISABLED;
      r_wrap_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_irq       <= 1'b0;
      r_rst_req   <= 1'b0;
      r_clr_n     <= 1'b0;
    end else begin
      r_clr_n <= 1'b1;
      case (r_state)
        ST_DISABLED: begin
          if (bus.wdg_en) begin
            r_state <= ST_ARMED;
          end else begin
            r_clr_n <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!bus.wdg_en) begin
            r_state <= ST_DISABLED;
            r_clr_n <= 1'b0;
          end else if (bus.kick) begin
            if (w_early_kick) begin
              r_state     <= ST_STAGE2;
              r_irq       <= 1'b1;
              r_rst_req   <= 1'b1;
              r_pulse_cnt <= '0;
            end else begin
              r_clr_n <= 1'b0;
            end
          end else if (w_wrap) begin
            r_state    <= ST_STAGE1;
            r_irq      <= 1'b1;
            r_wrap_cnt <= '0;
          end
        end
        ST_STAGE1: begin
          if (!bus.wdg_en) begin
            r_state    <= ST_DISABLED;
            r_irq      <= 1'b0;
            r_wrap_cnt <= '0;
            r_clr_n    <= 1'b0;
          end else if (bus.kick) begin
            r_state    <= ST_ARMED;
            r_irq      <= 1'b0;
            r_wrap_cnt <= '0;
            r_clr_n    <= 1'b0;
          end else if (w_wrap) begin
            if (r_wrap_cnt == WC_LAST) begin
              r_state     <= ST_STAGE2;
              r_rst_req   <= 1'b1;
              r_pulse_cnt <= '0;
              r_wrap_cnt  <= '0;
            end else begin
              r_wrap_cnt <= r_wrap_cnt + WC_ONE;
            end
          end
        end
        ST_STAGE2: begin
          // The bite runs to completion; kick and wdg_en are not looked at.
          if (r_pulse_cnt == PC_LAST) begin
            r_state     <= ST_DISABLED;
            r_irq       <= 1'b0;
            r_rst_req   <= 1'b0;
            r_pulse_cnt <= '0;
            r_clr_n     <= 1'b0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PC_ONE;
          end
        end
        default: begin
          r_state <= ST_DISABLED;
          r_clr_n <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stage       = r_state;
  assign bus.wdg_irq     = r_irq;
  assign bus.wdg_rst_req = r_rst_req;
  assign bus.cnt_clr_n   = r_clr_n;

endmodule
